// File: rtl/flexcounter_bank.sv
`default_nettype none
// ============================================================================
// flexcounter_bank : NCHAN independent up/down counters with terminal strobe,
//                    auto-reload or one-shot halt.        Revision 1.0
// ============================================================================
module flexcounter_bank #(
  parameter int NCHAN      = 4,
  parameter int COUNTSIZE  = 1024,
  parameter int COUNTWIDTH = $clog2(COUNTSIZE)
) (
  input  logic                                clk,
  input  logic                                RST,
  input  logic [NCHAN-1:0]                    enableCounter,
  input  logic [NCHAN-1:0]                    clearCounter,
  input  logic [NCHAN-1:0]                    countDown,
  input  logic [NCHAN-1:0]                    oneShot,
  input  logic [NCHAN-1:0][COUNTWIDTH-1:0]    maxCount,
  output logic [NCHAN-1:0][COUNTWIDTH-1:0]    count,
  output logic [NCHAN-1:0]                    strobe,
  output logic [NCHAN-1:0]                    done,
  output logic                                anyStrobe
);

  typedef enum logic [0:0] {
    ST_COUNT = 1'b0,
    ST_HALT  = 1'b1
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < NCHAN; gi++) begin : g_chan
      state_t                r_state, w_state_nxt;
      logic                  r_dir, w_dir_nxt;
      logic [COUNTWIDTH-1:0] r_count, w_count_nxt;
      logic                  r_strobe, w_strobe_nxt;
      logic                  r_done, w_done_nxt;
      logic                  w_at_term;
      logic [COUNTWIDTH-1:0] w_start_val;

      // Start value follows the newly requested direction, not the latched one.
      assign w_start_val = countDown[gi] ? maxCount[gi] : '0;
      // '>=' so a limit lowered below the running count still terminates.
      assign w_at_term   = r_dir ? (r_count == '0) : (r_count >= maxCount[gi]);

      always_comb begin
        w_state_nxt  = r_state;
        w_dir_nxt    = r_dir;
        w_count_nxt  = r_count;
        w_done_nxt   = r_done;
        w_strobe_nxt = 1'b0;
        if (clearCounter[gi]) begin
          w_dir_nxt   = countDown[gi];
          w_count_nxt = w_start_val;
          w_done_nxt  = 1'b0;
          w_state_nxt = ST_COUNT;
        end else if (r_state == ST_HALT) begin
          w_state_nxt = ST_HALT;
        end else if (enableCounter[gi]) begin
          if (!w_at_term) begin
            w_count_nxt = r_dir ? (r_count - COUNTWIDTH'(1))
                                : (r_count + COUNTWIDTH'(1));
          end else if (oneShot[gi]) begin
            w_strobe_nxt = 1'b1;
            w_done_nxt   = 1'b1;
            w_state_nxt  = ST_HALT;
          end else begin
            w_strobe_nxt = 1'b1;
            w_dir_nxt    = countDown[gi];
            w_count_nxt  = w_start_val;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (RST) begin
          r_state  <= ST_COUNT;
          r_dir    <= 1'b0;
          r_count  <= '0;
          r_strobe <= 1'b0;
          r_done   <= 1'b0;
        end else begin
          r_state  <= w_state_nxt;
          r_dir    <= w_dir_nxt;
          r_count  <= w_count_nxt;
          r_strobe <= w_strobe_nxt;
          r_done   <= w_done_nxt;
        end
      end

      assign count[gi]  = r_count;
      assign strobe[gi] = r_strobe;
      assign done[gi]   = r_done;
    end
  endgenerate

  assign anyStrobe = |strobe;

endmodule
`default_nettype wire
